// File: rtl/mealy_moore_detector_pkg.sv
// Shared definitions for the 10101 serial pattern detectors.
// State encoding is common to the Mealy and Moore machines.
package mealy_moore_detector_pkg;

    localparam int PATTERN_LEN = 5;
    localparam logic [PATTERN_LEN-1:0] PATTERN = 5'b10101;

    // Each state names the longest pattern prefix matched so far
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_e;

endpackage

// File: rtl/mealy_moore_detector_mealy.sv
// Mealy detector for 10101: the flag rises while the final bit is on din.
// Overlap is handled by falling back to S3 after a hit.
module mealy_moore_detector_mealy
    import mealy_moore_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic flag
);

    state_e state_q;
    state_e state_d;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = din ? S1 : S0;
            S1:      state_d = din ? S1 : S2;
            S2:      state_d = din ? S3 : S0;
            S3:      state_d = din ? S1 : S4;
            S4:      state_d = din ? S3 : S0;
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign flag = (state_q == S4) && din;

endmodule

// File: rtl/mealy_moore_detector_moore.sv
// Moore detector for 10101: S5 marks a completed match, flag is registered.
// The flag flop tracks the next state so it is high exactly while in S5.
module mealy_moore_detector_moore
    import mealy_moore_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic flag
);

    state_e state_q;
    state_e state_d;
    logic   flag_q;
    logic   flag_d;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = din ? S1 : S0;
            S1:      state_d = din ? S1 : S2;
            S2:      state_d = din ? S3 : S0;
            S3:      state_d = din ? S1 : S4;
            S4:      state_d = din ? S5 : S0;
            S5:      state_d = din ? S1 : S4;
            default: state_d = S0;
        endcase
        flag_d = (state_d == S5);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/mealy_moore_detector.sv
// Runs a Mealy and a Moore 10101 detector side by side on one stream.
// The Moore flag is the Mealy flag delayed by one clock.
module mealy_moore_detector
    import mealy_moore_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic mealy_flag,
    output logic moore_flag
);

    mealy_moore_detector_mealy u_mealy (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .flag (mealy_flag)
    );

    mealy_moore_detector_moore u_moore (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .flag (moore_flag)
    );

endmodule

// File: tb/tb_mealy_moore_detector.sv
// Bench for mealy_moore_detector: a shift-register reference model feeds
// a queue of {mealy, moore} expectations checked every bit period.
module tb_mealy_moore_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic mealy_flag;
    logic moore_flag;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q[$];
    logic [4:0] hist = '0;
    logic       prev_m = 1'b0;

    mealy_moore_detector dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .mealy_flag (mealy_flag),
        .moore_flag (moore_flag)
    );

    initial forever #5 clk = ~clk;

    task automatic model_clear();
        hist   = '0;
        prev_m = 1'b0;
        exp_q.delete();
    endtask

    // Drive one bit between edges and queue the model's expected flags
    task automatic drive(input logic b);
        logic m;
        @(negedge clk);
        din = b;
        m = ({hist[3:0], b} == 5'b10101);
        exp_q.push_back({m, prev_m});
        hist   = {hist[3:0], b};
        prev_m = m;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        din = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din = ~din;
            #1;
            checks++;
            if ({mealy_flag, moore_flag} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold: flags=%b required=00",
                         {mealy_flag, moore_flag});
            end
            @(posedge clk);
            #1;
            checks++;
            if ({mealy_flag, moore_flag} !== 2'b00) begin
                errors++;
                $display("FAIL reset_edge: flags=%b required=00",
                         {mealy_flag, moore_flag});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        din = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            logic [1:0] e;
            drive(1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({mealy_flag, moore_flag} !== e) begin
                errors++;
                $display("FAIL reset_after: flags=%b required=%b",
                         {mealy_flag, moore_flag}, e);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] stim = 8'b00101010;
        logic [7:0] mv   = 8'b00100000;
        logic [7:0] qv   = 8'b01000000;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            logic [1:0] e;
            drive(stim[i]);
            e = exp_q.pop_front();
            checks++;
            if ({mealy_flag, moore_flag} !== e ||
                {mealy_flag, moore_flag} !== {mv[i], qv[i]}) begin
                errors++;
                $display("FAIL single bit%0d: flags=%b required=%b",
                         i, {mealy_flag, moore_flag}, {mv[i], qv[i]});
            end
        end
    endtask

    task automatic test_overlap_word();
        logic [31:0] word = 32'h6AA36155;
        logic [31:0] mm;
        logic [31:0] qm;
        int mc = 0;
        int qc = 0;
        mm = (32'd1 << 4) | (32'd1 << 6) | (32'd1 << 8) |
             (32'd1 << 25) | (32'd1 << 27) | (32'd1 << 29);
        qm = mm << 1;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            logic [1:0] e;
            drive(word[i]);
            e = exp_q.pop_front();
            mc += int'(mealy_flag);
            qc += int'(moore_flag);
            checks++;
            if ({mealy_flag, moore_flag} !== {mm[i], qm[i]}) begin
                errors++;
                $display("FAIL word bit%0d: flags=%b required=%b",
                         i, {mealy_flag, moore_flag}, {mm[i], qm[i]});
            end
            checks++;
            if ({mealy_flag, moore_flag} !== e) begin
                errors++;
                $display("FAIL word_model bit%0d: flags=%b required=%b",
                         i, {mealy_flag, moore_flag}, e);
            end
        end
        checks++;
        if (mc != 6 || qc != 6) begin
            errors++;
            $display("FAIL word_pulses: mealy=%0d moore=%0d required=6/6",
                     mc, qc);
        end
    endtask

    task automatic test_near_miss();
        logic [12:0] stim = 13'b0010100101101;
        int pc = 0;
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            logic [1:0] e;
            drive(stim[i]);
            e = exp_q.pop_front();
            pc += int'(mealy_flag) + int'(moore_flag);
            checks++;
            if ({mealy_flag, moore_flag} !== e) begin
                errors++;
                $display("FAIL near_miss bit%0d: flags=%b required=%b",
                         i, {mealy_flag, moore_flag}, e);
            end
        end
        drive(1'b0);
        pc += int'(mealy_flag) + int'(moore_flag);
        void'(exp_q.pop_front());
        checks++;
        if (pc != 0) begin
            errors++;
            $display("FAIL near_miss_pulses: got=%0d required=0", pc);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] pre  = 4'b0101;
        logic [7:0] full = 8'b00010101;
        int mc = 0;
        int qc = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] e;
            drive(pre[i]);
            e = exp_q.pop_front();
            checks++;
            if ({mealy_flag, moore_flag} !== e) begin
                errors++;
                $display("FAIL mid_pre bit%0d: flags=%b required=%b",
                         i, {mealy_flag, moore_flag}, e);
            end
        end
        @(negedge clk);
        din = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mealy_flag, moore_flag} !== 2'b00) begin
            errors++;
            $display("FAIL mid_async: flags=%b required=00",
                     {mealy_flag, moore_flag});
        end
        @(negedge clk);
        rst = 1'b0;
        din = 1'b1;
        #1;
        checks++;
        if ({mealy_flag, moore_flag} !== 2'b00) begin
            errors++;
            $display("FAIL mid_release: flags=%b required=00",
                     {mealy_flag, moore_flag});
        end
        model_clear();
        hist = 5'b00001;
        for (int i = 0; i < 2; i++) begin
            logic [1:0] e;
            drive(1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({mealy_flag, moore_flag} !== e) begin
                errors++;
                $display("FAIL mid_after bit%0d: flags=%b required=%b",
                         i, {mealy_flag, moore_flag}, e);
            end
        end
        for (int i = 0; i < 8; i++) begin
            logic [1:0] e;
            drive(full[i]);
            e = exp_q.pop_front();
            mc += int'(mealy_flag);
            qc += int'(moore_flag);
            checks++;
            if ({mealy_flag, moore_flag} !== e) begin
                errors++;
                $display("FAIL mid_full bit%0d: flags=%b required=%b",
                         i, {mealy_flag, moore_flag}, e);
            end
        end
        checks++;
        if (mc != 1 || qc != 1) begin
            errors++;
            $display("FAIL mid_pulses: mealy=%0d moore=%0d required=1/1",
                     mc, qc);
        end
    endtask

    task automatic test_equivalence();
        logic dprev = 1'b0;
        apply_reset();
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                @(negedge clk);
                #2;
                rst = 1'b1;
                #1;
                checks++;
                if ({mealy_flag, moore_flag} !== 2'b00) begin
                    errors++;
                    $display("FAIL equiv_reset it%0d: flags=%b required=00",
                             i, {mealy_flag, moore_flag});
                end
                @(negedge clk);
                rst = 1'b0;
                din = 1'b0;
                model_clear();
                dprev = 1'b0;
            end else begin
                logic [1:0] e;
                drive(1'($urandom_range(0, 1)));
                e = exp_q.pop_front();
                checks++;
                if ({mealy_flag, moore_flag} !== e) begin
                    errors++;
                    $display("FAIL equiv_model it%0d: flags=%b required=%b",
                             i, {mealy_flag, moore_flag}, e);
                end
                checks++;
                if (moore_flag !== dprev) begin
                    errors++;
                    $display("FAIL equiv_delay it%0d: moore=%b required=%b",
                             i, moore_flag, dprev);
                end
                dprev = mealy_flag;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap_word();
        test_near_miss();
        test_mid_reset();
        test_equivalence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
